// File: rtl/vga_timing_rx.sv
// VGA timing receiver: recovers pixel coordinates from hsync/vsync/de,
// measures line/frame geometry against the expected mode and reports lock.
module vga_timing_rx #(
  parameter int H_ACTIVE        = 640,
  parameter int H_TOTAL         = 800,
  parameter int H_SYNC          = 96,
  parameter int V_ACTIVE        = 480,
  parameter int V_TOTAL         = 525,
  parameter int V_SYNC          = 2,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic        i_VGA_CLOCK,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  output logic        o_de,
  output logic [11:0] o_Sx,
  output logic [10:0] o_Sy,
  output logic        o_locked,
  output logic        o_frame_ok,
  output logic        o_err,
  output logic [11:0] o_h_total,
  output logic [10:0] o_v_total,
  output logic [11:0] o_h_active,
  output logic [10:0] o_v_active
);

  localparam logic [11:0] HT = 12'(H_TOTAL);
  localparam logic [11:0] HS = 12'(H_SYNC);
  localparam logic [11:0] HA = 12'(H_ACTIVE);
  localparam logic [11:0] HT_LAST = 12'(H_TOTAL - 1);
  localparam logic [10:0] VT = 11'(V_TOTAL);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] VS = 11'(V_SYNC);
  localparam logic [10:0] VT_LAST = 11'(V_TOTAL - 1);

  localparam int TO_LIM = 2 * H_TOTAL;
  localparam int TO_W = $clog2(TO_LIM + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIM - 1);
  localparam logic [TO_W-1:0] TO_END = TO_W'(TO_LIM);
  localparam logic [TO_W-1:0] TO_ONE = {{(TO_W-1){1'b0}}, 1'b1};

  localparam int GC_W = $clog2(LOCK_FRAMES + 1);
  localparam logic [GC_W-1:0] GC_LOCK = GC_W'(LOCK_FRAMES);
  localparam logic [GC_W-1:0] GC_ONE = {{(GC_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } state_t;

  function automatic logic [11:0] inc12(input logic [11:0] v);
    inc12 = (&v) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] inc11(input logic [10:0] v);
    inc11 = (&v) ? v : v + 11'd1;
  endfunction

  state_t state, state_d;
  logic [GC_W-1:0] good_cnt, good_d, good_inc;
  logic err_d, ok_d;

  logic hs, vs, hs_q, vs_q;
  logic line_start, vs_rise, de_rise, frame_start;
  logic seen_ls, sy_arm, frame_bad;
  logic [11:0] h_cnt, hsw_cnt, de_cnt;
  logic [10:0] v_cnt, va_cnt, vsw_cnt;
  logic [10:0] v_ln, va_ln;
  logic bad_ln, line_ok, frame_good;
  logic [TO_W-1:0] to_cnt;
  logic timeout;

  assign hs = i_hsync ^ SYNC_ACTIVE_LOW;
  assign vs = i_vsync ^ SYNC_ACTIVE_LOW;

  assign line_start = hs & ~hs_q;
  assign vs_rise = vs & ~vs_q;
  assign de_rise = i_de & ~o_de;
  assign frame_start = vs_rise & (line_start | seen_ls);

  // Saturated counters never equal a legal mode value, so they fail here.
  assign line_ok = (h_cnt == HT) && !(&h_cnt)
                && (hsw_cnt == HS) && !(&hsw_cnt)
                && ((de_cnt == HA) || (de_cnt == '0))
                && !(&de_cnt);

  // Closing line is folded in before the frame verdict.
  assign v_ln = line_start ? inc11(v_cnt) : v_cnt;
  assign va_ln = (line_start && de_cnt != '0) ? inc11(va_cnt) : va_cnt;
  assign bad_ln = frame_bad | (line_start & ~line_ok);

  assign frame_good = (v_ln == VT) && !(&v_ln)
                   && (va_ln == VA) && !(&va_ln)
                   && (vsw_cnt == VS) && !(&vsw_cnt)
                   && !bad_ln;

  assign timeout = (to_cnt == TO_LAST) && !line_start;
  assign good_inc = good_cnt + GC_ONE;

  always_comb begin
    state_d = state;
    good_d = good_cnt;
    err_d = o_err;
    ok_d = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      good_d = '0;
      if (state == LOCKED) err_d = 1'b1;
    end else if (frame_start) begin
      unique case (state)
        SEARCH: begin
          state_d = ACQUIRE;
          good_d = '0;
        end
        ACQUIRE: begin
          if (frame_good) begin
            ok_d = 1'b1;
            good_d = good_inc;
            if (good_inc >= GC_LOCK) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (frame_good) begin
            ok_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
            good_d = '0;
            err_d = 1'b1;
          end
        end
        default: begin
          state_d = SEARCH;
          good_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      state <= SEARCH;
      good_cnt <= '0;
      o_locked <= 1'b0;
      o_frame_ok <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_d;
      good_cnt <= good_d;
      o_locked <= (state_d == LOCKED);
      o_frame_ok <= ok_d;
      o_err <= err_d;
    end
  end

  always_ff @(posedge i_VGA_CLOCK) begin
    if (i_rst) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      o_de <= 1'b0;
      seen_ls <= 1'b0;
      sy_arm <= 1'b0;
      h_cnt <= '0;
      hsw_cnt <= '0;
      de_cnt <= '0;
      v_cnt <= '0;
      va_cnt <= '0;
      vsw_cnt <= '0;
      frame_bad <= 1'b0;
      to_cnt <= '0;
      o_Sx <= '0;
      o_Sy <= '0;
      o_h_total <= '0;
      o_v_total <= '0;
      o_h_active <= '0;
      o_v_active <= '0;
    end else begin
      hs_q <= hs;
      vs_q <= vs;
      o_de <= i_de;

      if (frame_start) seen_ls <= 1'b0;
      else if (line_start) seen_ls <= 1'b1;

      if (line_start) begin
        h_cnt <= 12'd1;
        hsw_cnt <= 12'd1;
        de_cnt <= {11'd0, i_de};
        o_h_total <= h_cnt;
        if (de_cnt != '0) o_h_active <= de_cnt;
      end else begin
        h_cnt <= inc12(h_cnt);
        if (hs) hsw_cnt <= inc12(hsw_cnt);
        if (i_de) de_cnt <= inc12(de_cnt);
      end

      if (frame_start) begin
        v_cnt <= '0;
        va_cnt <= '0;
        vsw_cnt <= {10'd0, line_start};
        frame_bad <= 1'b0;
        o_v_total <= v_ln;
        o_v_active <= va_ln;
      end else begin
        v_cnt <= v_ln;
        va_cnt <= va_ln;
        if (line_start && vs) vsw_cnt <= inc11(vsw_cnt);
        frame_bad <= bad_ln;
      end

      if (line_start) to_cnt <= '0;
      else if (to_cnt != TO_END) to_cnt <= to_cnt + TO_ONE;

      if (de_rise) o_Sx <= '0;
      else if (o_Sx == HT_LAST) o_Sx <= '0;
      else o_Sx <= o_Sx + 12'd1;

      // Row re-anchors on the first active pixel of each frame.
      if (frame_start) sy_arm <= 1'b1;
      else if (de_rise) sy_arm <= 1'b0;

      if (de_rise && sy_arm) o_Sy <= '0;
      else if (line_start) o_Sy <= (o_Sy == VT_LAST) ? '0 : o_Sy + 11'd1;
    end
  end

endmodule
